// File: rtl/rv_div_sched_pkg.sv
// Shared types for the round-robin divider scheduler.
// State encoding and requester-ID width helper.
package rv_div_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // An ID field of zero bits is illegal, so two requesters still get one bit
  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// Combinational round-robin pick: first valid requester
// at or after the pointer, wrapping around.
module rv_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = IDW'(w_j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_div_sched.sv
// Shares one serial divider among NREQ requesters, one
// operation in flight, results routed back by requester ID.
module rv_div_sched
  import rv_div_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int LANES = 1,
  parameter  int WIDTH = 32,
  parameter  int TAGW  = 1,
  localparam int IDW   = idw_of(NREQ),
  localparam int DW    = LANES * WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_numer,
  input  logic [NREQ*DW-1:0]   req_denom,
  input  logic [NREQ-1:0]      req_signed,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_quotient,
  output logic [DW-1:0]        rsp_remainder,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 div_valid_in,
  input  logic                 div_ready_in,
  output logic [DW-1:0]        div_numer,
  output logic [DW-1:0]        div_denom,
  output logic                 div_signed,
  output logic [IDW+TAGW-1:0]  div_tag_in,
  input  logic                 div_valid_out,
  output logic                 div_ready_out,
  input  logic [DW-1:0]        div_quotient,
  input  logic [DW-1:0]        div_remainder,
  input  logic [IDW+TAGW-1:0]  div_tag_out,
  output logic                 err_id,
  output logic [31:0]          busy_cycles
);

  state_t            r_state, w_next;
  logic [IDW-1:0]    r_ptr, r_id;
  logic [DW-1:0]     r_numer, r_denom;
  logic [DW-1:0]     r_quo, r_rem;
  logic              r_signed;
  logic [TAGW-1:0]   r_tag, r_rtag;
  logic              r_err;
  logic [31:0]       r_busy;

  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_idx, w_ptr_nx;
  logic              w_any, w_take, w_done;

  rv_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_ptr_nx = (int'(w_idx) == NREQ - 1) ? '0
                  : w_idx + 1'b1;
  assign w_take = (r_state == S_IDLE) && w_any;
  assign w_done = (r_state == S_WAIT) && div_valid_out;

  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    rsp_valid     = '0;
    div_valid_in  = 1'b0;
    div_ready_out = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Drain any result left over from before a reset
        div_ready_out = div_valid_out;
        if (w_any) begin
          req_ready = w_gnt;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_valid_in = 1'b1;
        if (div_ready_in) w_next = S_WAIT;
      end
      S_WAIT: begin
        div_ready_out = 1'b1;
        if (div_valid_out) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_id] = 1'b1;
        if (rsp_ready[r_id]) w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      r_busy  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) r_ptr <= w_ptr_nx;
      if (w_done && div_tag_out[IDW+TAGW-1:TAGW] != r_id)
        r_err <= 1'b1;
      if (r_state != S_IDLE && r_busy != '1)
        r_busy <= r_busy + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_id     <= w_idx;
      r_numer  <= req_numer[int'(w_idx)*DW +: DW];
      r_denom  <= req_denom[int'(w_idx)*DW +: DW];
      r_signed <= req_signed[w_idx];
      r_tag    <= req_tag[int'(w_idx)*TAGW +: TAGW];
    end
    if (w_done) begin
      r_quo  <= div_quotient;
      r_rem  <= div_remainder;
      r_rtag <= div_tag_out[TAGW-1:0];
    end
  end

  assign div_numer     = r_numer;
  assign div_denom     = r_denom;
  assign div_signed    = r_signed;
  assign div_tag_in    = {r_id, r_tag};
  assign rsp_quotient  = r_quo;
  assign rsp_remainder = r_rem;
  assign rsp_tag       = r_rtag;
  assign err_id        = r_err;
  assign busy_cycles   = r_busy;

endmodule

// File: tb/tb_rv_div_sched.sv
// Directed bench for rv_div_sched with a behavioural
// serial divider (result 33 cycles after push).
module tb_rv_div_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_numer, req_denom;
  logic [3:0]   req_signed, req_tag;
  logic [3:0]   rsp_valid, rsp_ready;
  logic [31:0]  rsp_quotient, rsp_remainder;
  logic [0:0]   rsp_tag;
  logic         div_valid_in, div_ready_in;
  logic [31:0]  div_numer, div_denom;
  logic         div_signed;
  logic [2:0]   div_tag_in, div_tag_out;
  logic         div_valid_out, div_ready_out;
  logic [31:0]  div_quotient, div_remainder;
  logic         err_id;
  logic [31:0]  busy_cycles;

  int checks = 0;
  int errors = 0;

  logic        drst_n, rdy_en, flip_id, dbusy;
  int          dcnt;
  logic [31:0] dq, dr;
  logic [2:0]  dtag;

  always #5 clk = ~clk;

  rv_div_sched dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_numer     (req_numer),
    .req_denom     (req_denom),
    .req_signed    (req_signed),
    .req_tag       (req_tag),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_tag       (rsp_tag),
    .div_valid_in  (div_valid_in),
    .div_ready_in  (div_ready_in),
    .div_numer     (div_numer),
    .div_denom     (div_denom),
    .div_signed    (div_signed),
    .div_tag_in    (div_tag_in),
    .div_valid_out (div_valid_out),
    .div_ready_out (div_ready_out),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_tag_out   (div_tag_out),
    .err_id        (err_id),
    .busy_cycles   (busy_cycles)
  );

  // Divider stand-in, independent of the scheduler reset
  assign div_ready_in  = rdy_en && !dbusy;
  assign div_valid_out = dbusy && (dcnt == 0);
  assign div_quotient  = dq;
  assign div_remainder = dr;
  assign div_tag_out   = flip_id ? (dtag ^ 3'b010) : dtag;

  always_ff @(posedge clk or negedge drst_n) begin
    if (!drst_n) begin
      dbusy <= 1'b0;
      dcnt  <= 0;
    end else if (!dbusy) begin
      if (div_valid_in && div_ready_in) begin
        dbusy <= 1'b1;
        dcnt  <= 32;
        dtag  <= div_tag_in;
        if (div_signed) begin
          dq <= $signed(div_numer) / $signed(div_denom);
          dr <= $signed(div_numer) % $signed(div_denom);
        end else begin
          dq <= div_numer / div_denom;
          dr <= div_numer % div_denom;
        end
      end
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end else if (div_ready_out) begin
      dbusy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input logic [31:0] n,
                      input logic [31:0] d, input logic s,
                      input logic t);
    req_numer[r*32 +: 32] = n;
    req_denom[r*32 +: 32] = d;
    req_signed[r] = s;
    req_tag[r]    = t;
  endtask

  // Returns at the negedge of the first rsp_valid cycle, or -1
  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) return;
      tick();
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic accept(input int r);
    tick();
    rsp_ready = 4'b0001 << r;
    tick();
    rsp_ready = 4'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; drst_n = 1'b0;
    rdy_en = 1'b1; flip_id = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_numer = '0; req_denom = '0;
    req_signed = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hs got %b exp 0",
               {req_ready, rsp_valid});
    end
    checks++;
    if ({div_valid_in, div_ready_out, err_id} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000",
               {div_valid_in, div_ready_out, err_id});
    end
    checks++;
    if (busy_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_busy got %0d exp 0", busy_cycles);
    end
    #1;
    reset = 1'b1; drst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int          order[5] = '{0, 1, 2, 3, 0};
    logic [31:0] erem[4]  = '{0, 1, 2, 3};
    logic        etag[4]  = '{0, 1, 0, 1};
    int cyc, g;
    tick();
    for (int r = 0; r < 4; r++)
      load(r, 32'd50 + 32'(r), 32'd5, 1'b0, r[0]);
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = order[i];
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (req_ready != 4'b0) break;
        tick();
      end
      checks++;
      if (req_ready !== (4'b0001 << g)) begin
        errors++;
        $display("FAIL rr_grant%0d got %b exp %b",
                 i, req_ready, 4'b0001 << g);
      end
      tick();
      if (i == 4) req_valid = 4'b0;
      wait_rsp(1, cyc);
      checks++;
      if (cyc != 35) begin
        errors++;
        $display("FAIL rr_lat%0d got %0d exp 35", i, cyc);
      end
      checks++;
      if (rsp_valid !== (4'b0001 << g) ||
          rsp_quotient !== 32'd10 ||
          rsp_remainder !== erem[g] ||
          rsp_tag !== etag[g]) begin
        errors++;
        $display("FAIL rr_rsp%0d got v=%b q=%0d r=%0d t=%b exp v=%b q=10 r=%0d t=%b",
                 i, rsp_valid, rsp_quotient, rsp_remainder,
                 rsp_tag, 4'b0001 << g, erem[g], etag[g]);
      end
      tick();
    end
    rsp_ready = 4'b0;
  endtask

  task automatic test_single();
    int cyc;
    logic [31:0] b0;
    tick();
    load(2, 32'd100, 32'd7, 1'b0, 1'b1);
    req_valid = 4'b0100;
    @(negedge clk);
    b0 = busy_cycles;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant got %b exp 0100", req_ready);
    end
    tick();
    req_valid = 4'b0;
    wait_rsp(1, cyc);
    checks++;
    if (cyc != 35) begin
      errors++;
      $display("FAIL single_lat got %0d exp 35", cyc);
    end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_quotient !== 32'd14 ||
        rsp_remainder !== 32'd2 || rsp_tag !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp got v=%b q=%0d r=%0d t=%b exp v=0100 q=14 r=2 t=1",
               rsp_valid, rsp_quotient, rsp_remainder, rsp_tag);
    end
    accept(2);
    @(negedge clk);
    checks++;
    if (busy_cycles - b0 !== 32'd36 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_busy got %0d v=%b exp 36 v=0000",
               busy_cycles - b0, rsp_valid);
    end
  endtask

  task automatic test_signed();
    int cyc;
    tick();
    load(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL signed_grant got %b exp 0001", req_ready);
    end
    tick();
    req_valid = 4'b0;
    wait_rsp(1, cyc);
    checks++;
    if (rsp_valid !== 4'b0001 ||
        rsp_quotient !== 32'hFFFF_FFF2 ||
        rsp_remainder !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL signed_rsp got v=%b q=%h r=%h exp v=0001 q=fffffff2 r=fffffffe",
               rsp_valid, rsp_quotient, rsp_remainder);
    end
    accept(0);
  endtask

  task automatic test_issue_stall();
    int cyc;
    tick();
    rdy_en = 1'b0;
    load(1, 32'd1000, 32'd10, 1'b0, 1'b0);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_grant got %b exp 0010", req_ready);
    end
    tick();
    req_valid = 4'b0;
    load(1, 32'd5, 32'd5, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (div_valid_in !== 1'b1 || div_numer !== 32'd1000 ||
          div_denom !== 32'd10) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b n=%0d d=%0d exp v=1 n=1000 d=10",
                 k, div_valid_in, div_numer, div_denom);
      end
      tick();
    end
    rdy_en = 1'b1;
    wait_rsp(6, cyc);
    checks++;
    if (cyc != 40 || rsp_quotient !== 32'd100 ||
        rsp_remainder !== 32'd0) begin
      errors++;
      $display("FAIL stall_rsp got c=%0d q=%0d r=%0d exp c=40 q=100 r=0",
               cyc, rsp_quotient, rsp_remainder);
    end
    accept(1);
  endtask

  task automatic test_backpressure();
    int cyc;
    tick();
    load(3, 32'd9, 32'd2, 1'b0, 1'b1);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_grant got %b exp 1000", req_ready);
    end
    tick();
    load(0, 32'd20, 32'd6, 1'b0, 1'b0);
    req_valid = 4'b0001;
    wait_rsp(1, cyc);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_quotient !== 32'd4 ||
          rsp_remainder !== 32'd1 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b q=%0d r=%0d rdy=%b exp v=1000 q=4 r=1 rdy=0000",
                 k, rsp_valid, rsp_quotient, rsp_remainder,
                 req_ready);
      end
    end
    tick();
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = 4'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b v=%b exp rdy=0001 v=0000",
               req_ready, rsp_valid);
    end
    tick();
    req_valid = 4'b0;
    wait_rsp(1, cyc);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_quotient !== 32'd3 ||
        rsp_remainder !== 32'd2) begin
      errors++;
      $display("FAIL bp_next got v=%b q=%0d r=%0d exp v=0001 q=3 r=2",
               rsp_valid, rsp_quotient, rsp_remainder);
    end
    accept(0);
  endtask

  task automatic test_id_error();
    int cyc;
    tick();
    flip_id = 1'b1;
    load(1, 32'd30, 32'd4, 1'b0, 1'b0);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || err_id !== 1'b0) begin
      errors++;
      $display("FAIL iderr_pre got rdy=%b e=%b exp rdy=0010 e=0",
               req_ready, err_id);
    end
    tick();
    req_valid = 4'b0;
    wait_rsp(1, cyc);
    checks++;
    if (rsp_valid !== 4'b0010 || err_id !== 1'b1 ||
        rsp_quotient !== 32'd7) begin
      errors++;
      $display("FAIL iderr_rsp got v=%b e=%b q=%0d exp v=0010 e=1 q=7",
               rsp_valid, err_id, rsp_quotient);
    end
    accept(1);
    flip_id = 1'b0;
  endtask

  task automatic test_reset_flush();
    int seen;
    tick();
    load(2, 32'd100, 32'd7, 1'b0, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0;
    repeat (9) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0 || div_valid_in !== 1'b0 ||
        busy_cycles !== 32'd0 || err_id !== 1'b0) begin
      errors++;
      $display("FAIL flush_rst got v=%b vi=%b b=%0d e=%b exp 0",
               rsp_valid, div_valid_in, busy_cycles, err_id);
    end
    tick();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (div_valid_out) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (seen != 1 || div_ready_out !== 1'b1 ||
        rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL flush_drain got seen=%0d ro=%b v=%b exp seen=1 ro=1 v=0000",
               seen, div_ready_out, rsp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (div_valid_out !== 1'b0 || rsp_valid !== 4'b0 ||
        err_id !== 1'b0 || busy_cycles !== 32'd0) begin
      errors++;
      $display("FAIL flush_after got vo=%b v=%b e=%b b=%0d exp 0",
               div_valid_out, rsp_valid, err_id, busy_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_signed();
    test_issue_stall();
    test_backpressure();
    test_id_error();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
